// File: rtl/led_fade_controller.sv
// led_fade_controller
// Brightness trajectory sequencer feeding the PWM stage duty input.
// Accepts fade / breathe commands on a valid/ready handshake and walks
// an 8-bit duty level one LSB per step, with steps paced by a free-running
// prescaler tick and a per-command tick count.

module led_fade_controller #(
  parameter logic [31:0] TICK_DIV      = 32'd100000,
  parameter logic [7:0]  DEFAULT_LEVEL = 8'h00
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_step_ticks,
  input  logic       cmd_breathe,
  output logic [7:0] pwm_width,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FADE    = 2'd1,
    ST_BREATHE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_presc;
  logic [7:0]  r_step_cnt;
  logic [7:0]  r_target;
  logic [7:0]  r_step_ticks;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic        r_up;
  logic [7:0]  r_width;
  logic        r_done;

  logic        w_tick;
  logic        w_accept;
  logic        w_jump;
  logic        w_step_due;
  logic        w_step;
  logic [7:0]  w_fade_next;
  logic [7:0]  w_breathe_next;
  logic        w_breathe_up_next;

  assign w_tick     = (r_presc == (TICK_DIV - 32'd1));
  assign w_accept   = cmd_valid & cmd_ready;
  // A fade that needs no stepping completes on the accept edge itself.
  assign w_jump     = ~cmd_breathe & ((cmd_step_ticks == 8'd0) | (cmd_target == r_width));
  // step_ticks == 0 means every tick is a step.
  assign w_step_due = (r_step_ticks == 8'd0) | (r_step_cnt == (r_step_ticks - 8'd1));
  assign w_step     = w_tick & w_step_due & ~w_accept;

  // Free-running prescaler, wraps at TICK_DIV-1; never disturbed by commands.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_presc <= 32'd0;
    end else if (w_tick) begin
      r_presc <= 32'd0;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  // One-LSB move toward the fade target; the compare clamps it so it never wraps.
  always_comb begin
    w_fade_next = r_width;
    if (r_width < r_target) begin
      w_fade_next = r_width + 8'd1;
    end else if (r_width > r_target) begin
      w_fade_next = r_width - 8'd1;
    end else begin
      w_fade_next = r_width;
    end
  end

  // Breathe step: flip direction at a bound without moving, or jump between bounds when step_ticks is 0.
  always_comb begin
    w_breathe_next    = r_width;
    w_breathe_up_next = r_up;
    if (r_step_ticks == 8'd0) begin
      if (r_up) begin
        w_breathe_next    = r_hi;
        w_breathe_up_next = 1'b0;
      end else begin
        w_breathe_next    = r_lo;
        w_breathe_up_next = 1'b1;
      end
    end else if (r_up) begin
      if (r_width == r_hi) begin
        w_breathe_up_next = 1'b0;
      end else begin
        w_breathe_next = r_width + 8'd1;
      end
    end else begin
      if (r_width == r_lo) begin
        w_breathe_up_next = 1'b1;
      end else begin
        w_breathe_next = r_width - 8'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: accepts in IDLE/BREATHE, FADE exits on the step that lands on target.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_BREATHE: begin
        if (w_accept) begin
          if (cmd_breathe) begin
            w_state_next = ST_BREATHE;
          end else if (w_jump) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_FADE;
          end
        end else begin
          w_state_next = r_state;
        end
      end
      ST_FADE: begin
        if (w_step && (w_fade_next == r_target)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_FADE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and busy derive directly from the registered state.
  always_comb begin
    cmd_ready = (r_state != ST_FADE);
    busy      = (r_state != ST_IDLE);
    pwm_width = r_width;
    done      = r_done;
  end

  // Command latch, step counter and duty trajectory; an accept overrides a coincident tick.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_target     <= 8'd0;
      r_step_ticks <= 8'd0;
      r_step_cnt   <= 8'd0;
      r_lo         <= 8'd0;
      r_hi         <= 8'd0;
      r_up         <= 1'b1;
      r_width      <= DEFAULT_LEVEL;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_target     <= cmd_target;
        r_step_ticks <= cmd_step_ticks;
        r_step_cnt   <= 8'd0;
        if (cmd_breathe) begin
          if (cmd_target > r_width) begin
            r_lo <= r_width;
            r_hi <= cmd_target;
            r_up <= 1'b1;
          end else begin
            r_lo <= cmd_target;
            r_hi <= r_width;
            r_up <= 1'b0;
          end
        end else if (w_jump) begin
          r_width <= cmd_target;
          r_done  <= 1'b1;
        end
      end else if (w_tick && (r_state != ST_IDLE)) begin
        if (w_step_due) begin
          r_step_cnt <= 8'd0;
          if (r_state == ST_FADE) begin
            r_width <= w_fade_next;
            r_done  <= (w_fade_next == r_target);
          end else begin
            r_width <= w_breathe_next;
            r_up    <= w_breathe_up_next;
          end
        end else begin
          r_step_cnt <= r_step_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_fade_controller.sv
// Testbench for led_fade_controller: directed scenarios plus randomized
// commands, checked against a tick-counting behavioural model.

module tb_led_fade_controller;

  localparam int TD = 4;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_target = 8'h00;
  logic [7:0] cmd_step_ticks = 8'h00;
  logic       cmd_breathe = 1'b0;
  logic [7:0] pwm_width;
  logic       busy;
  logic       done;

  int n_pass = 0;
  int n_total = 0;

  // Model state: mode 0 idle, 1 fade, 2 breathe.
  int m_mode = 0;
  int m_width = 32'h20;
  int m_target = 0;
  int m_st = 0;
  int m_lo = 0;
  int m_hi = 0;
  bit m_up = 1'b1;
  bit m_done = 1'b0;
  int m_edge = 0;
  int m_ticks = 0;
  bit m_tick_last = 1'b0;

  led_fade_controller #(.TICK_DIV(32'd4), .DEFAULT_LEVEL(8'h20)) dut (
    .clk_50(clk_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step_ticks(cmd_step_ticks), .cmd_breathe(cmd_breathe),
    .pwm_width(pwm_width), .busy(busy), .done(done)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Advance one clock edge and update the model from the rules: ticks every TD
  // edges since reset, a step on every step_ticks-th tick counted after accept.
  task automatic step_clk();
    bit acc, brth;
    int tgt, st;
    acc  = cmd_valid && (m_mode != 1);
    brth = cmd_breathe;
    tgt  = int'(cmd_target);
    st   = int'(cmd_step_ticks);
    @(posedge clk_50);
    if (reset) begin
      m_mode = 0; m_width = 32'h20; m_done = 1'b0; m_edge = 0; m_ticks = 0;
      m_up = 1'b1; m_tick_last = 1'b0;
    end else begin
      m_done = 1'b0;
      m_edge++;
      m_tick_last = (m_edge % TD == 0);
      if (acc) begin
        m_target = tgt; m_st = st; m_ticks = 0;
        if (brth) begin
          m_mode = 2;
          m_lo = (tgt < m_width) ? tgt : m_width;
          m_hi = (tgt > m_width) ? tgt : m_width;
          m_up = (tgt > m_width);
        end else if (st == 0 || tgt == m_width) begin
          m_width = tgt; m_done = 1'b1; m_mode = 0;
        end else begin
          m_mode = 1;
        end
      end else if (m_tick_last && m_mode != 0) begin
        m_ticks++;
        if (m_st == 0 || (m_ticks % m_st) == 0) begin
          if (m_mode == 1) begin
            m_width = m_width + ((m_target > m_width) ? 1 : -1);
            if (m_width == m_target) begin m_done = 1'b1; m_mode = 0; end
          end else if (m_st == 0) begin
            m_width = m_up ? m_hi : m_lo; m_up = !m_up;
          end else if (m_up) begin
            if (m_width == m_hi) m_up = 1'b0; else m_width++;
          end else begin
            if (m_width == m_lo) m_up = 1'b1; else m_width--;
          end
        end
      end
    end
    #1;
  endtask

  // Present one command for one edge, then drop valid.
  task automatic send(input logic [7:0] tgt, input logic [7:0] st, input logic br);
    cmd_target = tgt; cmd_step_ticks = st; cmd_breathe = br; cmd_valid = 1'b1;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    step_clk(); step_clk();
    n_total++;
    if ({pwm_width, done, busy, cmd_ready} !== {8'h20, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got w=%h d=%b b=%b r=%b, need w=20 d=0 b=0 r=1", pwm_width, done, busy, cmd_ready);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_fade_up();
    int seen, last_cyc;
    logic [7:0] prev;
    send(8'h00, 8'd0, 1'b0);
    n_total++;
    if (pwm_width !== 8'h00 || done !== 1'b1) $display("FAIL fade_up_jump0: got w=%h d=%b, need w=00 d=1", pwm_width, done);
    else n_pass++;
    send(8'h05, 8'd1, 1'b0);
    n_total++;
    if ({busy, cmd_ready} !== 2'b10) $display("FAIL fade_up_accept: got busy=%b ready=%b, need 1 0", busy, cmd_ready);
    else n_pass++;
    seen = 0; last_cyc = -1; prev = pwm_width;
    for (int c = 0; c < 30; c++) begin
      step_clk();
      n_total++;
      if ({pwm_width, done, busy, cmd_ready} !== {8'(m_width), m_done, m_mode != 0, m_mode != 1})
        $display("FAIL fade_up_model: got %h/%b/%b/%b need %h/%b/%b/%b", pwm_width, done, busy, cmd_ready, 8'(m_width), m_done, m_mode != 0, m_mode != 1);
      else n_pass++;
      if (pwm_width !== prev) begin
        if (last_cyc >= 0) begin
          n_total++;
          if (c - last_cyc != 4) $display("FAIL fade_up_spacing: got %0d cycles between steps, need 4", c - last_cyc);
          else n_pass++;
        end
        last_cyc = c; prev = pwm_width;
      end
      if (done === 1'b1) begin
        seen++;
        n_total++;
        if (pwm_width !== 8'h05 || busy !== 1'b0) $display("FAIL fade_up_done: got w=%h busy=%b, need 05 0", pwm_width, busy);
        else n_pass++;
      end
    end
    n_total++;
    if (seen != 1) $display("FAIL fade_up_done_count: got %0d pulses, need 1", seen);
    else n_pass++;
  endtask

  task automatic test_jump();
    send(8'h10, 8'd0, 1'b0);
    send(8'hF0, 8'd0, 1'b0);
    n_total++;
    if ({pwm_width, done, busy} !== {8'hF0, 1'b1, 1'b0}) $display("FAIL jump_f0: got w=%h d=%b b=%b, need F0 1 0", pwm_width, done, busy);
    else n_pass++;
    step_clk();
    n_total++;
    if ({pwm_width, done} !== {8'hF0, 1'b0}) $display("FAIL jump_after: got w=%h d=%b, need F0 0", pwm_width, done);
    else n_pass++;
  endtask

  task automatic test_breathe();
    logic [7:0] seq [7];
    int k;
    seq = '{8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd2, 8'd3};
    send(8'h02, 8'd0, 1'b0);
    send(8'h04, 8'd1, 1'b1);
    k = 0;
    for (int c = 0; c < 40; c++) begin
      step_clk();
      n_total++;
      if ({pwm_width, done, busy, cmd_ready} !== {8'(m_width), 1'b0, 1'b1, 1'b1})
        $display("FAIL breathe_model: got %h/%b/%b/%b need %h/0/1/1", pwm_width, done, busy, cmd_ready, 8'(m_width));
      else n_pass++;
      if (m_tick_last && k < 7) begin
        n_total++;
        if (pwm_width !== seq[k]) $display("FAIL breathe_seq%0d: got %h, need %h", k, pwm_width, seq[k]);
        else n_pass++;
        k++;
      end
    end
    n_total++;
    if (k != 7) $display("FAIL breathe_steps: got %0d ticks, need 7", k);
    else n_pass++;
  endtask

  task automatic test_preempt();
    logic [7:0] w0;
    bit seen;
    for (int c = 0; c < TD && ((m_edge + 1) % TD != 0); c++) step_clk();
    w0 = pwm_width;
    send(8'h00, 8'd1, 1'b0);
    n_total++;
    if ({pwm_width, busy, cmd_ready} !== {w0, 1'b1, 1'b0}) $display("FAIL preempt_edge: got w=%h b=%b r=%b, need %h 1 0", pwm_width, busy, cmd_ready, w0);
    else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      step_clk();
      n_total++;
      if ({pwm_width, done, busy, cmd_ready} !== {8'(m_width), m_done, m_mode != 0, m_mode != 1})
        $display("FAIL preempt_model: got %h/%b/%b/%b need %h/%b/%b/%b", pwm_width, done, busy, cmd_ready, 8'(m_width), m_done, m_mode != 0, m_mode != 1);
      else n_pass++;
      seen = (done === 1'b1);
    end
    n_total++;
    if (!seen || pwm_width !== 8'h00) $display("FAIL preempt_done: got seen=%b w=%h, need 1 00", seen, pwm_width);
    else n_pass++;
  endtask

  task automatic test_held_valid();
    bit seen;
    send(8'h03, 8'd0, 1'b0);
    cmd_target = 8'h06; cmd_step_ticks = 8'd1; cmd_breathe = 1'b0; cmd_valid = 1'b1;
    step_clk();
    cmd_target = 8'h01;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      step_clk();
      n_total++;
      if (pwm_width < 8'h03 || pwm_width !== 8'(m_width) || done !== m_done)
        $display("FAIL held_ignored: got w=%h d=%b, need w=%h d=%b", pwm_width, done, 8'(m_width), m_done);
      else n_pass++;
      seen = (done === 1'b1);
    end
    n_total++;
    if (!seen || pwm_width !== 8'h06 || cmd_ready !== 1'b1) $display("FAIL held_first_done: got seen=%b w=%h r=%b, need 1 06 1", seen, pwm_width, cmd_ready);
    else n_pass++;
    step_clk();
    cmd_valid = 1'b0;
    n_total++;
    if ({pwm_width, busy, cmd_ready} !== {8'h06, 1'b1, 1'b0}) $display("FAIL held_accept: got w=%h b=%b r=%b, need 06 1 0", pwm_width, busy, cmd_ready);
    else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      step_clk();
      n_total++;
      if ({pwm_width, done, busy} !== {8'(m_width), m_done, m_mode != 0})
        $display("FAIL held_model: got %h/%b/%b need %h/%b/%b", pwm_width, done, busy, 8'(m_width), m_done, m_mode != 0);
      else n_pass++;
      seen = (done === 1'b1);
    end
    n_total++;
    if (!seen || pwm_width !== 8'h01) $display("FAIL held_second_done: got seen=%b w=%h, need 1 01", seen, pwm_width);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [7:0] e;
    send(8'hFF, 8'd0, 1'b0);
    send(8'hFF, 8'd2, 1'b0);
    n_total++;
    if ({pwm_width, done, busy} !== {8'hFF, 1'b1, 1'b0}) $display("FAIL ff_to_ff: got w=%h d=%b b=%b, need FF 1 0", pwm_width, done, busy);
    else n_pass++;
    send(8'hFE, 8'd0, 1'b0);
    send(8'hFF, 8'd1, 1'b0);
    for (int c = 0; c < 20; c++) step_clk();
    n_total++;
    if ({pwm_width, busy} !== {8'hFF, 1'b0}) $display("FAIL no_wrap_ff: got w=%h b=%b, need FF 0", pwm_width, busy);
    else n_pass++;
    send(8'h00, 8'd0, 1'b0);
    send(8'h00, 8'd1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step_clk();
      n_total++;
      if ({pwm_width, done, busy} !== {8'h00, 1'b0, 1'b1}) $display("FAIL breathe_flat: got w=%h d=%b b=%b, need 00 0 1", pwm_width, done, busy);
      else n_pass++;
    end
    send(8'hFF, 8'd0, 1'b1);
    e = 8'h00;
    for (int c = 0; c < 16; c++) begin
      step_clk();
      if (m_tick_last) e = ~e;
      n_total++;
      if ({pwm_width, done} !== {e, 1'b0}) $display("FAIL breathe_toggle: got w=%h d=%b, need %h 0", pwm_width, done, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    send(8'h30, 8'd0, 1'b0);
    send(8'h50, 8'd1, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step_clk();
      hit = (pwm_width === 8'h40);
    end
    n_total++;
    if (!hit || busy !== 1'b1) $display("FAIL reset_mid_reach40: got w=%h b=%b, need 40 1", pwm_width, busy);
    else n_pass++;
    reset = 1'b1;
    step_clk();
    n_total++;
    if ({pwm_width, done, busy, cmd_ready} !== {8'h20, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_mid: got w=%h d=%b b=%b r=%b, need 20 0 0 1", pwm_width, done, busy, cmd_ready);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    int t;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        t = m_width + int'($urandom_range(0, 16)) - 8;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        cmd_target = 8'(t);
        cmd_step_ticks = 8'($urandom_range(0, 3));
        cmd_breathe = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      step_clk();
      n_total++;
      if ({pwm_width, done, busy, cmd_ready} !== {8'(m_width), m_done, m_mode != 0, m_mode != 1})
        $display("FAIL random_model cyc%0d: got %h/%b/%b/%b need %h/%b/%b/%b", c, pwm_width, done, busy, cmd_ready, 8'(m_width), m_done, m_mode != 0, m_mode != 1);
      else n_pass++;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_jump();
    test_breathe();
    test_preempt();
    test_held_valid();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_fade_controller.md
# led_fade_controller

Brightness sequencer directly upstream of the PWM LED stage. Accepts fade/breathe commands over a valid/ready handshake and walks an 8-bit duty value toward a target at a programmable rate. `pwm_width` drives the PWM stage's duty input; the PWM stage owns carrier generation, and this block owns only the brightness trajectory.

## Interface
- `TICK_DIV`, default 100000: clk_50 cycles per prescaler tick, giving 2 ms at 50 MHz. Legal range is 1..2^32-1.
- `DEFAULT_LEVEL`, default 8'h00: value of `pwm_width` after reset.
- `clk_50`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_target`  in  8  target duty level.
- `cmd_step_ticks`  in  8  prescaler ticks per 1-LSB step. 0 means jump.
- `cmd_breathe`  in  1  0 = fade to target and hold; 1 = oscillate between start level and target forever.
- `pwm_width`  out  8  current duty level, driven to the PWM stage.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a fade reaches its target.

## Operation
- States:
  - IDLE: `cmd_ready=1`.
  - FADE: `cmd_ready=0`.
  - BREATHE: `cmd_ready=1`, so a new command preempts breathing.
- Accept condition: `cmd_valid & cmd_ready` at a clock edge. On accept, latch target, step_ticks and mode, and clear the step counter.
  - Fade mode: go to FADE.
  - Breathe mode: go to BREATHE. Latch lo = min(`pwm_width`, target) and hi = max(`pwm_width`, target). Set direction up if target > `pwm_width`, otherwise down.
- Prescaler: a 32-bit free-running counter, 0..TICK_DIV-1. It emits `tick` on the cycle it wraps to 0. It is not cleared on accept.
- Step counter: 8-bit. On each `tick` in FADE or BREATHE:
  - If step_cnt == step_ticks-1: take one step and clear step_cnt.
  - Otherwise: increment step_cnt.
- FADE step:
  - `pwm_width` moves ±1 toward the target.
  - When the new value equals the target, or the fade was accepted with target == `pwm_width`: pulse `done` in the same cycle the final value appears, then return to IDLE.
- BREATHE step, mirroring the PWM-stage sweep behaviour:
  - Direction up and `pwm_width`==hi: flip the direction with no change to width.
  - Direction up otherwise: +1.
  - Direction down: symmetric, using lo.
  - If lo==hi, `pwm_width` stays constant and the block remains in BREATHE.
  - `done` never pulses in BREATHE.
- step_ticks == 0:
  - FADE: `pwm_width` = target on the cycle after accept, `done` pulses on that same cycle, then IDLE.
  - BREATHE: the width toggles between lo and hi on every tick.
- Arithmetic: `pwm_width` never wraps. It is clamped by the compare against target/lo/hi, so 8'hFF+1 and 8'h00-1 never occur.
- Command while not ready: ignored. `cmd_valid` may stay high. No input is buffered.

## Timing
- Reset values:
  - `pwm_width`=DEFAULT_LEVEL, `cmd_ready`=1, `busy`=0, `done`=0.
  - State IDLE, prescaler=0, step_cnt=0, direction=up.
- Reset mid-fade or mid-breathe: all of the above apply on the next edge, and the in-flight command is discarded.
- Accept at edge N: `busy`=1 and `cmd_ready` reflects the new state from cycle N+1.
- First step lands on the step_ticks-th tick after accept. The delay is between (step_ticks-1)·TICK_DIV+1 and step_ticks·TICK_DIV cycles, depending on prescaler phase.
- Each step and `done` are registered outputs that update on a tick edge. `done` is high for exactly 1 cycle.
- `busy` falls in the same cycle `done` is high. `cmd_ready` returns to 1 in that cycle.
- Preempt in BREATHE: if `tick` and accept fall on the same edge, the accept wins and no breathe step is taken on that edge.
- `pwm_width` changes at most once per tick. The PWM stage samples duty at its own period boundary, so no extra handshake is required.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then fade to 8'h05 with step_ticks=1 from 0 → `pwm_width` counts 1..5, one step every 4 cycles; `done` pulses once with width=5; `busy` falls in the same cycle.
- Fade with step_ticks=0 from 8'h10 to 8'hF0 → width=F0 one cycle after accept, `done` in that same cycle, never passes through intermediate values.
- Breathe from 8'h02 to 8'h04, step_ticks=1 → sequence 3,4,4(flip),3,2,2(flip),3…; `done` stays 0; `cmd_ready` stays 1.
- Issue a fade to 8'h00 during BREATHE, with the accept on the same edge as a tick → no breathe step on that edge; descent to 0 at the fade rate, then `done`.
- `cmd_valid` held high during a FADE → ignored until `done`, then accepted on the next edge; boundary checks: fade from FF to FF pulses `done` immediately; no wrap at 00/FF.
- Assert `reset` mid-fade with width=8'h40 and DEFAULT_LEVEL=8'h20 → next edge: width=20, `busy`=0, `cmd_ready`=1, `done`=0.
